// File: rtl/msg_pad_buf.sv
// msg_pad_buf
//   Packs big-endian 32-bit message words into BLK_W-word hash blocks and
//   appends SHA-2 padding: 0x80 marker, zero fill, LEN_W-bit message length.
//   An extra block is emitted when the marker or length does not fit.
//
// Ports
//   clk, rst (async, active-high), clr (sync abort)
//   in_valid/in_ready/in_data/in_bytes/in_last : word stream from host/DMA
//   blk_valid/blk_ready/blk_data               : block handshake to the core
//   blk_first/blk_last                         : block position in its message
module msg_pad_buf #(
   parameter int unsigned BLK_W = 16,
   parameter int unsigned LEN_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_data,
   input  logic [2:0]            in_bytes,
   input  logic                  in_last,
   output logic                  blk_valid,
   input  logic                  blk_ready,
   output logic [BLK_W*32-1:0]   blk_data,
   output logic                  blk_first,
   output logic                  blk_last
);

   localparam int unsigned PW      = $clog2(BLK_W);
   localparam int unsigned LW      = LEN_W / 32;
   localparam int unsigned LEN_POS = BLK_W - LW;   // index of first length word

   typedef enum logic [1:0] {FILL, PAD, HOLD, XBLK} state_t;

   state_t            state, state_nxt;
   logic [31:0]       mem [BLK_W];
   logic [PW-1:0]     wptr;
   logic [LEN_W-1:0]  len_cnt;
   logic              pad_pend, len_pend, first_flg;
   logic [2:0]        tail_bytes;

   logic              accept, wptr_end;
   logic [2:0]        eff_bytes;
   logic [31:0]       byte_mask, pad_word;
   logic [PW:0]       pad_idx;
   logic              wrap_pad, fits;

   assign in_ready  = (state == FILL) & ~rst;
   assign blk_valid = (state == HOLD);
   assign accept    = in_valid & in_ready;
   assign wptr_end  = (wptr == PW'(BLK_W - 1));

   always_comb begin
      for (int unsigned i = 0; i < BLK_W; i++)
         blk_data[(BLK_W - i) * 32 - 1 -: 32] = mem[i];
   end

   // Out-of-range byte counts are handled as a full word
   always_comb begin
      eff_bytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
      case (eff_bytes)
         3'd0:    byte_mask = 32'h0000_0000;
         3'd1:    byte_mask = 32'hFF00_0000;
         3'd2:    byte_mask = 32'hFFFF_0000;
         3'd3:    byte_mask = 32'hFFFF_FF00;
         default: byte_mask = 32'hFFFF_FFFF;
      endcase
   end

   // Marker position: a full tail word pushes the marker to byte 0 of the next word
   always_comb begin
      case (tail_bytes)
         3'd1:    pad_word = 32'h0080_0000;
         3'd2:    pad_word = 32'h0000_8000;
         3'd3:    pad_word = 32'h0000_0080;
         default: pad_word = 32'h8000_0000;
      endcase
      pad_idx  = {1'b0, wptr} + {{PW{1'b0}}, (tail_bytes == 3'd4)};
      wrap_pad = (tail_bytes == 3'd4) && wptr_end;
      fits     = (32'(pad_idx) < LEN_POS);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL: if (accept) begin
            if (in_last)       state_nxt = PAD;
            else if (wptr_end) state_nxt = HOLD;
         end
         PAD:  state_nxt = HOLD;
         HOLD: if (blk_ready) state_nxt = (pad_pend | len_pend) ? XBLK : FILL;
         XBLK: state_nxt = HOLD;
         default: state_nxt = FILL;
      endcase
      if (clr) state_nxt = FILL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < BLK_W; i++) mem[i] <= '0;
         wptr       <= '0;
         len_cnt    <= '0;
         pad_pend   <= 1'b0;
         len_pend   <= 1'b0;
         first_flg  <= 1'b1;
         tail_bytes <= '0;
         blk_first  <= 1'b0;
         blk_last   <= 1'b0;
      end else if (clr) begin
         for (int unsigned i = 0; i < BLK_W; i++) mem[i] <= '0;
         wptr       <= '0;
         len_cnt    <= '0;
         pad_pend   <= 1'b0;
         len_pend   <= 1'b0;
         first_flg  <= 1'b1;
         tail_bytes <= '0;
         blk_first  <= 1'b0;
         blk_last   <= 1'b0;
      end else begin
         case (state)
            FILL: if (accept) begin
               if (in_last) begin
                  mem[wptr]  <= in_data & byte_mask;
                  len_cnt    <= len_cnt + LEN_W'({eff_bytes, 3'b000});
                  tail_bytes <= eff_bytes;
               end else begin
                  mem[wptr] <= in_data;
                  len_cnt   <= len_cnt + LEN_W'(32);
                  wptr      <= wptr_end ? '0 : wptr + 1'b1;
                  if (wptr_end) begin
                     blk_first <= first_flg;
                     blk_last  <= 1'b0;
                  end
               end
            end
            PAD: begin
               blk_first <= first_flg;
               if (wrap_pad) begin
                  pad_pend <= 1'b1;
                  blk_last <= 1'b0;
               end else begin
                  // Bytes after the tail were stored as zero, so OR places the marker
                  mem[pad_idx[PW-1:0]] <= mem[pad_idx[PW-1:0]] | pad_word;
                  if (fits) begin
                     for (int unsigned k = 0; k < LW; k++)
                        mem[LEN_POS + k] <= len_cnt[LEN_W - 1 - 32 * k -: 32];
                     blk_last <= 1'b1;
                  end else begin
                     len_pend <= 1'b1;
                     blk_last <= 1'b0;
                  end
               end
            end
            HOLD: if (blk_ready) begin
               first_flg <= blk_last;
               for (int unsigned i = 0; i < BLK_W; i++) mem[i] <= '0;
               wptr <= '0;
               if (blk_last) len_cnt <= '0;
            end
            XBLK: begin
               for (int unsigned k = 0; k < LW; k++)
                  mem[LEN_POS + k] <= len_cnt[LEN_W - 1 - 32 * k -: 32];
               if (pad_pend) mem[0] <= 32'h8000_0000;
               pad_pend  <= 1'b0;
               len_pend  <= 1'b0;
               blk_first <= first_flg;
               blk_last  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_msg_pad_buf.sv
module tb_msg_pad_buf;

   logic clk = 1'b0;
   logic rst, clr, in_valid, in_last, blk_ready, sel;
   logic [31:0] in_data;
   logic [2:0]  in_bytes;

   logic iv16, br16, ir16, bv16, bf16, bl16;
   logic iv32, br32, ir32, bv32, bf32, bl32;
   logic [511:0]  bd16;
   logic [1023:0] bd32;

   logic cur_in_ready, cur_blk_valid, cur_first, cur_last;
   logic [1023:0] cur_blk_data;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]    msg[$];
   logic [1023:0] exp_data[$];
   logic          exp_first[$];
   logic          exp_last[$];
   logic [1023:0] last_blk;

   always #5 clk = ~clk;

   assign iv16 = in_valid & ~sel;
   assign br16 = blk_ready & ~sel;
   assign iv32 = in_valid & sel;
   assign br32 = blk_ready & sel;

   assign cur_in_ready  = sel ? ir32 : ir16;
   assign cur_blk_valid = sel ? bv32 : bv16;
   assign cur_first     = sel ? bf32 : bf16;
   assign cur_last      = sel ? bl32 : bl16;
   assign cur_blk_data  = sel ? bd32 : {512'b0, bd16};

   msg_pad_buf #(.BLK_W(16), .LEN_W(64)) u16 (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(iv16), .in_ready(ir16), .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
      .blk_valid(bv16), .blk_ready(br16), .blk_data(bd16), .blk_first(bf16), .blk_last(bl16));

   msg_pad_buf #(.BLK_W(32), .LEN_W(128)) u32 (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(iv32), .in_ready(ir32), .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
      .blk_valid(bv32), .blk_ready(br32), .blk_data(bd32), .blk_first(bf32), .blk_last(bl32));

   task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_random_msg(input int n);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
   endtask

   // Reference: standard SHA-2 padding on a byte string, then cut into blocks
   task automatic build_model();
      logic [7:0]    pad[$];
      logic [63:0]   bits;
      logic [1023:0] v;
      int bb, lb, nblk, sh;
      bb = sel ? 128 : 64;
      lb = sel ? 16 : 8;
      bits = 64'(msg.size()) * 64'd8;
      pad = msg;
      pad.push_back(8'h80);
      while ((pad.size() % bb) != (bb - lb)) pad.push_back(8'h00);
      for (int i = 0; i < lb; i++) begin
         sh = (lb - 1 - i) * 8;
         pad.push_back((sh < 64) ? 8'(bits >> sh) : 8'h00);
      end
      nblk = pad.size() / bb;
      exp_data.delete(); exp_first.delete(); exp_last.delete();
      for (int b = 0; b < nblk; b++) begin
         v = '0;
         for (int j = 0; j < bb; j++) v = (v << 8) | 1024'(pad[b * bb + j]);
         exp_data.push_back(v);
         exp_first.push_back(b == 0);
         exp_last.push_back(b == nblk - 1);
      end
   endtask

   task automatic run_msg(input int bp);
      int n, nwords, idx, cyc, expect_at, bp_left, nb, blkw;
      logic [31:0] w;
      n = msg.size();
      nwords = (n == 0) ? 1 : (n + 3) / 4;
      blkw = sel ? 32 : 16;
      idx = 0; cyc = 0; expect_at = -1; bp_left = bp;
      build_model();
      while ((idx < nwords || exp_data.size() > 0) && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (expect_at == cyc) begin
            chk("latency", 1024'(cur_blk_valid), 1024'(1));
            expect_at = -1;
         end
         if (idx < nwords) begin
            nb = n - 4 * idx;
            if (nb > 4) nb = 4;
            w = '0;
            for (int k = 0; k < 4; k++)
               w = {w[23:0], (k < nb) ? msg[4 * idx + k] : 8'($urandom)};
            in_valid = ($urandom % 4) != 0;
            in_data  = w;
            in_bytes = 3'(nb);
            in_last  = (idx == nwords - 1);
         end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_bytes = 3'd4;
         end
         if (cur_blk_valid) begin
            if (exp_data.size() == 0) begin
               chk("extra_block", 1024'(cur_blk_valid), 1024'(0));
               blk_ready = 1'b1;
            end else begin
               if (bp_left > 0) begin
                  blk_ready = 1'b0;
                  bp_left--;
                  chk("bp_data", cur_blk_data, exp_data[0]);
                  chk("bp_in_ready", 1024'(cur_in_ready), 1024'(0));
               end else begin
                  blk_ready = ($urandom % 3) != 0;
               end
               if (blk_ready) begin
                  chk("blk_data", cur_blk_data, exp_data[0]);
                  chk("blk_first", 1024'(cur_first), 1024'(exp_first[0]));
                  chk("blk_last", 1024'(cur_last), 1024'(exp_last[0]));
                  last_blk = cur_blk_data;
                  void'(exp_data.pop_front());
                  void'(exp_first.pop_front());
                  void'(exp_last.pop_front());
               end
            end
         end else begin
            blk_ready = 1'($urandom % 2);
         end
         if (in_valid && cur_in_ready) begin
            if (in_last) expect_at = cyc + 2;
            else if (((idx + 1) % blkw) == 0) expect_at = cyc + 1;
            idx++;
         end
      end
      chk("msg_complete", 1024'(idx == nwords && exp_data.size() == 0), 1024'(1));
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0; in_bytes = 3'd4;
   endtask

   task automatic feed_partial(input int k);
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = $urandom; in_bytes = 3'd4; in_last = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_in_ready"}, 1024'(cur_in_ready), 1024'(0));
      chk({tag, "_blk_valid"}, 1024'(cur_blk_valid), 1024'(0));
      chk({tag, "_blk_first"}, 1024'(cur_first), 1024'(0));
      chk({tag, "_blk_last"}, 1024'(cur_last), 1024'(0));
      chk({tag, "_blk_data"}, cur_blk_data, 1024'(0));
   endtask

   task automatic set_abc();
      msg.delete();
      msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
      in_data = '0; in_bytes = 3'd4; sel = 1'b0;
      repeat (2) @(negedge clk);
      chk_idle_outputs("reset16");
      sel = 1'b1;
      #1 chk_idle_outputs("reset32");
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 1024'(cur_in_ready), 1024'(1));

      // BLK_W=16
      set_abc();
      run_msg(0);
      chk("t1_w0", 1024'(last_blk[511 -: 32]), 1024'(32'h6162_6380));
      chk("t1_w15", 1024'(last_blk[31:0]), 1024'(32'h0000_0018));
      set_random_msg(0);
      run_msg(0);
      chk("t2_w0", 1024'(last_blk[511 -: 32]), 1024'(32'h8000_0000));
      set_random_msg(56);
      run_msg(5);
      chk("t3_w15", 1024'(last_blk[31:0]), 1024'(32'h0000_01C0));
      set_random_msg(64);
      run_msg(0);
      chk("t4_w0", 1024'(last_blk[511 -: 32]), 1024'(32'h8000_0000));
      chk("t4_w15", 1024'(last_blk[31:0]), 1024'(32'h0000_0200));

      // rst pulse mid-message
      feed_partial(5);
      #2 rst = 1'b1;
      #1 chk_idle_outputs("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      set_abc();
      run_msg(0);
      chk("rst_abc_w0", 1024'(last_blk[511 -: 32]), 1024'(32'h6162_6380));

      // clr mid-message
      feed_partial(7);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_blk_valid", 1024'(cur_blk_valid), 1024'(0));
      set_random_msg(20);
      run_msg(0);

      for (int m = 0; m < 12; m++) begin
         set_random_msg(int'($urandom_range(0, 200)));
         run_msg(int'($urandom_range(0, 3)));
      end
      set_random_msg(55); run_msg(0);
      set_random_msg(60); run_msg(0);
      set_random_msg(128); run_msg(0);

      // BLK_W=32, LEN_W=128
      sel = 1'b1;
      @(negedge clk);
      set_abc();
      run_msg(0);
      chk("t6_w0", 1024'(last_blk[1023 -: 32]), 1024'(32'h6162_6380));
      chk("t6_w31", 1024'(last_blk[31:0]), 1024'(32'h0000_0018));
      set_random_msg(112);
      run_msg(2);
      chk("t6b_w31", 1024'(last_blk[31:0]), 1024'(32'h0000_0380));
      set_random_msg(128); run_msg(0);
      for (int m = 0; m < 8; m++) begin
         set_random_msg(int'($urandom_range(0, 300)));
         run_msg(int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
